// File: rtl/div_share_ctrl_pkg.sv
// Shared types and helpers for the shared-divider controller.
package div_share_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LAUNCH,
    WAIT,
    RESP
  } div_ctrl_state_t;

  // Requester id width; a single requester still needs one id bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_share_ctrl_if.sv
// Request/response bundle between requesters and the shared-divider controller.
interface div_share_ctrl_if
  import div_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [IDW-1:0]             rsp_id;
  logic [WIDTH-1:0]           rsp_val;
  logic                       rsp_dbz;
  logic                       rsp_ovf;
  logic                       busy;

  // Requesters and the response consumer.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_val, rsp_dbz, rsp_ovf, busy
  );

  // The controller.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_val, rsp_dbz, rsp_ovf, busy
  );

endinterface

// File: rtl/div.sv
// Signed fixed-point divider: val = (a << FBITS) / b, truncated toward zero.
// Restoring division on magnitudes, one quotient bit per cycle; done pulses
// WIDTH+FBITS cycles after start. Any operand equal to the most negative value,
// or a quotient whose magnitude reaches 2^(WIDTH-1), is reported as overflow
// (so the result range is symmetric). Divide by zero wins over overflow.
module div #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] val,
  output logic             dbz,
  output logic             ovf
);
  localparam int N  = WIDTH + FBITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic           run;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] rem;
  logic [N-1:0]   quo;
  logic [WIDTH-1:0] dvs;
  logic           neg, zero, minop;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  logic [N-1:0]     quo_nx;
  logic             big;
  logic [WIDTH-1:0] q_lo;
  logic             unused_div;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    mag_a  = a[WIDTH-1] ? -a : a;
    mag_b  = b[WIDTH-1] ? -b : b;
    rem_sh = {rem, quo[N-1]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = rem_sh >= {1'b0, dvs};
    quo_nx = {quo[N-2:0], ge};
    big    = |quo_nx[N-1:WIDTH-1];
    q_lo   = quo_nx[WIDTH-1:0];
  end

  // Remainder after a subtract is always below the divisor.
  assign unused_div = diff[WIDTH];

  // Load on start, iterate N steps, then publish result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      run   <= 1'b0;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg   <= 1'b0;
      zero  <= 1'b0;
      minop <= 1'b0;
      done  <= 1'b0;
      val   <= '0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !run) begin
        run   <= 1'b1;
        cnt   <= CW'(N);
        rem   <= '0;
        quo   <= {mag_a, {FBITS{1'b0}}};
        dvs   <= mag_b;
        neg   <= a[WIDTH-1] ^ b[WIDTH-1];
        zero  <= (b == '0);
        minop <= (a == MINV) || (b == MINV);
      end else if (run) begin
        rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo <= quo_nx;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
          dbz  <= zero;
          ovf  <= !zero && (minop || big);
          val  <= (zero || minop || big) ? '0 : (neg ? -q_lo : q_lo);
        end
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one fixed-point divider among NREQ requesters.
// One division in flight; result returned on a tagged response channel.
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FBITS = 16,
  parameter int NREQ  = 4
) (
  input  logic             clk,
  input  logic             rst,
  div_share_ctrl_if.slave  bus
);
  localparam int IDW = id_width(NREQ);

  div_ctrl_state_t  state;
  logic [IDW-1:0]   rr;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic [IDW-1:0]   lat_id;
  logic             start;

  logic             rsp_valid_q, rsp_dbz_q, rsp_ovf_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_val_q;

  logic             div_done, div_dbz, div_ovf;
  logic [WIDTH-1:0] div_val;

  logic             pick_ok;
  logic [IDW-1:0]   pick_id;
  logic [IDW:0]     idx;

  // First valid requester at or after the rr pointer, wrapping modulo NREQ.
  always_comb begin
    pick_ok = 1'b0;
    pick_id = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!pick_ok && bus.req_valid[idx[IDW-1:0]]) begin
        pick_ok = 1'b1;
        pick_id = idx[IDW-1:0];
      end
    end
  end

  // Accept must coincide with the GRANT-cycle valids, so it is decoded from
  // state rather than registered; a requester that dropped out gets nothing.
  always_comb begin
    bus.req_ready = '0;
    if (state == GRANT && pick_ok) bus.req_ready[pick_id] = 1'b1;
  end

  // Controller FSM: grant, launch, wait for the divider, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr          <= '0;
      lat_a       <= '0;
      lat_b       <= '0;
      lat_id      <= '0;
      start       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_val_q   <= '0;
      rsp_dbz_q   <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|bus.req_valid) state <= GRANT;
        GRANT: begin
          if (pick_ok) begin
            lat_a  <= bus.req_a[pick_id];
            lat_b  <= bus.req_b[pick_id];
            lat_id <= pick_id;
            rr     <= (pick_id == IDW'(NREQ-1)) ? '0 : pick_id + IDW'(1);
            start  <= 1'b1;
            state  <= LAUNCH;
          end else begin
            state  <= IDLE;
          end
        end
        LAUNCH: begin
          start <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= lat_id;
            rsp_val_q   <= div_val;
            rsp_dbz_q   <= div_dbz;
            rsp_ovf_q   <= div_ovf;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_val   = rsp_val_q;
  assign bus.rsp_dbz   = rsp_dbz_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.busy      = (state != IDLE);

  div #(
    .WIDTH (WIDTH),
    .FBITS (FBITS)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (lat_a),
    .b     (lat_b),
    .done  (div_done),
    .val   (div_val),
    .dbz   (div_dbz),
    .ovf   (div_ovf)
  );

endmodule
